// File: rtl/mult_div_ctrl_if.sv
// Handshake and result bus of the MULT/DIV sequencer.
// The master side issues requests and the slave side (the sequencer) returns busy/done and HI/LO.
interface mult_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic             is_unsigned;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, is_unsigned, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, is_unsigned, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Multicycle MIPS MULT/DIV sequencer: shift-add multiplier and restoring divider, one bit per cycle, owning HI/LO.
// Optional macro MULTDIV_UNSIGNED_EN enables the MULTU/DIVU variants selected by is_unsigned.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input logic           clock,
    input logic           reset,
    mult_div_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + ONE_2W;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
        if (is_signed && x[WIDTH-1]) begin
            return neg_w(x);
        end else begin
            return x;
        end
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             neg_p_q, neg_p_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             signed_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_acc_s, mul_low_s;
    logic [WIDTH:0]   div_sh_s, div_diff_s;
    logic [WIDTH-1:0] div_acc_s, div_low_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

`ifdef MULTDIV_UNSIGNED_EN
    assign signed_s = ~bus.is_unsigned;
`else
    logic unused_s;
    assign unused_s = bus.is_unsigned;
    assign signed_s = 1'b1;
`endif

    // One iteration of each engine plus the sign fixup; acc/low hold {prod_hi, prod_lo} or {rem, quo}.
    always_comb begin
        if (low_q[0]) begin
            mul_sum_s = {1'b0, acc_q} + {1'b0, opnd_q};
        end else begin
            mul_sum_s = {1'b0, acc_q};
        end
        mul_acc_s = mul_sum_s[WIDTH:1];
        mul_low_s = {mul_sum_s[0], low_q[WIDTH-1:1]};

        div_sh_s   = {acc_q, low_q[WIDTH-1]};
        div_diff_s = div_sh_s - {1'b0, opnd_q};
        if (div_sh_s >= {1'b0, opnd_q}) begin
            div_acc_s = div_diff_s[WIDTH-1:0];
            div_low_s = {low_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_s = div_sh_s[WIDTH-1:0];
            div_low_s = {low_q[WIDTH-2:0], 1'b0};
        end

        if (neg_p_q) begin
            prod_fix_s = neg_2w({acc_q, low_q});
            quo_fix_s  = neg_w(low_q);
        end else begin
            prod_fix_s = {acc_q, low_q};
            quo_fix_s  = low_q;
        end
        if (neg_r_q) begin
            rem_fix_s = neg_w(acc_q);
        end else begin
            rem_fix_s = acc_q;
        end
    end

    // Next-state and register-update logic for the IDLE/RUN/FIX/DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        acc_d   = acc_q;
        low_d   = low_q;
        opnd_d  = opnd_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    cnt_d   = CNT_ZERO;
                    dz_d    = 1'b0;
                    neg_p_d = signed_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_r_d = signed_s & bus.a[WIDTH-1];
                    acc_d   = ZERO_W;
                    // Dividend shifts out of low while quotient bits shift in; multiplier shifts out the same way.
                    if (bus.op) begin
                        low_d  = magnitude(bus.a, signed_s);
                        opnd_d = magnitude(bus.b, signed_s);
                    end else begin
                        low_d  = magnitude(bus.b, signed_s);
                        opnd_d = magnitude(bus.a, signed_s);
                    end
                    if (bus.op && (bus.b == ZERO_W)) begin
                        state_d = S_DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (op_q) begin
                    acc_d = div_acc_s;
                    low_d = div_low_s;
                end else begin
                    acc_d = mul_acc_s;
                    low_d = mul_low_s;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_FIX: begin
                if (op_q) begin
                    hi_d = rem_fix_s;
                    lo_d = quo_fix_s;
                end else begin
                    hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix_s[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            op_q    <= 1'b0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
            acc_q   <= ZERO_W;
            low_q   <= ZERO_W;
            opnd_q  <= ZERO_W;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= ZERO_W;
            lo_q    <= ZERO_W;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
            acc_q   <= acc_d;
            low_q   <= low_d;
            opnd_q  <= opnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized self-checking bench for mult_div_ctrl against an arithmetic reference model.
module tb_mult_div_ctrl;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mult_div_ctrl_if #(.WIDTH(W)) bus_if ();
    mult_div_ctrl #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] mdl_hi = 32'h0;
    logic [W-1:0] mdl_lo = 32'h0;
    logic         mdl_dz = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result of MULT/DIV from plain 64-bit arithmetic.
    function automatic void model(input logic op_i, input logic uns_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i);
        logic uns_eff;
        longint sa, sb, q, r;
        logic [63:0] p;
`ifdef MULTDIV_UNSIGNED_EN
        uns_eff = uns_i;
`else
        uns_eff = 1'b0;
`endif
        sa = $signed(a_i);
        sb = $signed(b_i);
        if (!op_i) begin
            if (uns_eff) p = {32'h0, a_i} * {32'h0, b_i};
            else         p = sa * sb;
            mdl_hi = p[63:32];
            mdl_lo = p[31:0];
            mdl_dz = 1'b0;
        end else if (b_i == 32'h0) begin
            mdl_dz = 1'b1;
        end else begin
            mdl_dz = 1'b0;
            if (uns_eff) begin
                mdl_lo = a_i / b_i;
                mdl_hi = a_i % b_i;
            end else begin
                q = sa / sb;
                r = sa % sb;
                p = q; mdl_lo = p[31:0];
                p = r; mdl_hi = p[31:0];
            end
        end
    endfunction

    task automatic run_op(input logic op_i, input logic uns_i, input logic [W-1:0] a_i,
                          input logic [W-1:0] b_i, input bit poke, input string tag);
        int lat;
        int busy_err;
        int extra_done;
        logic dz_case;
        dz_case = op_i && (b_i == 32'h0);
        model(op_i, uns_i, a_i, b_i);
        @(negedge clock);
        bus_if.start = 1'b1; bus_if.op = op_i; bus_if.is_unsigned = uns_i;
        bus_if.a = a_i; bus_if.b = b_i;
        @(posedge clock); #1;
        bus_if.start = 1'b0;
        bus_if.a = $urandom; bus_if.b = $urandom;
        bus_if.op = 1'($urandom_range(0, 1));
        lat = 1; busy_err = 0;
        while (!bus_if.done && lat < 60) begin
            if (!bus_if.busy) busy_err++;
            if (poke && lat == 5) begin
                bus_if.start = 1'b1; bus_if.op = ~op_i;
                bus_if.a = a_i + 32'd1; bus_if.b = b_i ^ 32'h5;
            end
            if (poke && lat == 9) bus_if.start = 1'b0;
            @(posedge clock); #1;
            lat++;
        end
        check_val({tag, "_latency"}, 64'(lat), dz_case ? 64'd1 : 64'(W + 2));
        check_val({tag, "_busy_run"}, 64'(busy_err), 64'd0);
        check_val({tag, "_busy_done"}, 64'(bus_if.busy), 64'd0);
        check_val({tag, "_hi"}, 64'(bus_if.hi), 64'(mdl_hi));
        check_val({tag, "_lo"}, 64'(bus_if.lo), 64'(mdl_lo));
        check_val({tag, "_dz"}, 64'(bus_if.div_zero), 64'(mdl_dz));
        @(posedge clock); #1;
        check_val({tag, "_done_pulse"}, 64'(bus_if.done), 64'd0);
        if (poke) begin
            extra_done = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clock); #1;
                if (bus_if.done) extra_done++;
            end
            check_val({tag, "_no_2nd_done"}, 64'(extra_done), 64'd0);
            check_val({tag, "_hi_held"}, 64'(bus_if.hi), 64'(mdl_hi));
        end
    endtask

    task automatic reset_mid_op();
        @(negedge clock);
        bus_if.start = 1'b1; bus_if.op = 1'b0; bus_if.is_unsigned = 1'b0;
        bus_if.a = 32'h1234_5678; bus_if.b = 32'h9abc_def0;
        @(posedge clock); #1;
        bus_if.start = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        mdl_hi = 32'h0; mdl_lo = 32'h0; mdl_dz = 1'b0;
        check_val("rst_mid_busy", 64'(bus_if.busy), 64'd0);
        check_val("rst_mid_done", 64'(bus_if.done), 64'd0);
        check_val("rst_mid_hi", 64'(bus_if.hi), 64'd0);
        check_val("rst_mid_lo", 64'(bus_if.lo), 64'd0);
        @(posedge clock); #1;
        check_val("rst_mid_idle", 64'({bus_if.busy, bus_if.done}), 64'd0);
    endtask

    logic [W-1:0] ra, rb;

    initial begin
        reset = 1'b0;
        bus_if.start = 1'b0; bus_if.op = 1'b0; bus_if.is_unsigned = 1'b0;
        bus_if.a = 32'h0; bus_if.b = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        check_val("reset_busy", 64'(bus_if.busy), 64'd0);
        check_val("reset_done", 64'(bus_if.done), 64'd0);
        check_val("reset_dz", 64'(bus_if.div_zero), 64'd0);
        check_val("reset_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul_7_m3");
        check_val("mul_7_m3_const", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        check_val("div_m7_2_const", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1'b0, 1'b0, 32'd100, 32'hFFFF_FF00, 1'b0, "mul_prior");
        run_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, "div_zero");
        run_op(1'b0, 1'b0, 32'd3, 32'd4, 1'b0, "dz_clear");
        run_op(1'b0, 1'b0, 32'h0001_0003, 32'h0002_0005, 1'b1, "restart_ign");
        reset_mid_op();
        run_op(1'b0, 1'b0, 32'd3, 32'd4, 1'b0, "mul_after_rst");
        check_val("mul_after_rst_const", {bus_if.hi, bus_if.lo}, 64'd12);
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, "mulu");
        run_op(1'b1, 1'b1, 32'hFFFF_FFF0, 32'd3, 1'b0, "divu");
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: rb = rb;
            endcase
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb, 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Multicycle sequencer for the MIPS MULT/DIV instructions. It sits beside the ALU, is started by ControlUnit with operands taken from registers A and B, and iterates one bit per cycle through a shift-add multiplier and a restoring divider. It owns the HI/LO registers and returns a one-cycle done pulse. ControlUnit holds its wait state while busy is high.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  request; sampled only in IDLE
op  in  1  0 = MULT, 1 = DIV
is_unsigned  in  1  unsigned variant; see Optional Feature
a  in  WIDTH  multiplicand / dividend (rs)
b  in  WIDTH  multiplier / divisor (rt)
busy  out  1  high in RUN and FIX
done  out  1  one-cycle pulse in DONE
div_zero  out  1  sticky; set when a DIV has b==0, cleared by the next accepted start
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset==0 at a rising edge):
  - state goes to IDLE.
  - hi, lo, busy, done and div_zero all go to 0.
  - Iteration counter and internal shift registers are cleared.
  - Reset during RUN or FIX aborts the operation, and hi/lo are zeroed.
- States: IDLE, RUN, FIX, DONE.
- IDLE with start==1:
  - a and b are latched, the counter is zeroed and div_zero is cleared.
  - Operands are converted to magnitudes. Signs are recorded: product/quotient sign = a[msb]^b[msb]; remainder sign = a[msb].
  - If op==DIV and b==0: go directly to DONE and set div_zero=1. hi/lo are unchanged. done is seen 1 edge after the start edge.
  - Otherwise go to RUN.
- RUN lasts exactly WIDTH cycles, one iteration per cycle:
  - MULT: 2*WIDTH product register; add the multiplicand if the product LSB is 1, then shift right.
  - DIV: restoring step. Shift {rem, quo} left; if rem >= divisor, subtract and set the quotient LSB.
  - After iteration WIDTH-1, go to FIX.
- FIX, 1 cycle: apply the sign fixup (two's-complement negate) and load hi/lo at the FIX→DONE edge.
  - MULT: {hi, lo} = the full 2*WIDTH signed product.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - -2^(W-1) / -1 gives lo = 0x80000000, hi = 0 (wraps, no flag).
- DONE, 1 cycle: done=1, busy=0, hi/lo are valid; then go to IDLE.
- Latency: for non-zero-divisor operations, done is high in the cycle after edge WIDTH+2 counted from the start-sampling edge (edge 34 for WIDTH=32).
- start is ignored in RUN, FIX and DONE. Operand changes after the start edge have no effect.
- hi/lo hold their value between operations. They change only at the FIX→DONE edge or on reset.

Optional Feature:
MULTDIV_UNSIGNED_EN
- Defined: is_unsigned==1 at start selects MULTU/DIVU. Magnitude conversion and sign fixup are skipped, and latency is unchanged.
- Not defined: is_unsigned is ignored (treated as 0); all operations are signed.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) → done in the cycle after edge 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for edges 1..33, done high for exactly 1 cycle.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
- DIV a=5, b=0 after a prior MULT → done after 1 edge, div_zero=1, hi/lo keep the prior MULT result; the next start clears div_zero.
- Re-assert start with different operands during RUN → ignored; the result matches the first operands; no second done pulse.
- Drive reset low at edge 10 of a MULT → next cycle is IDLE, busy=0, hi=lo=0, no done; a fresh MULT 3*4 then gives lo=12, hi=0.
- With MULTDIV_UNSIGNED_EN: MULTU a=0xFFFFFFFF, b=2 → hi=1, lo=0xFFFFFFFE. Without the macro, the same stimulus → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
